// File: rtl/clock_group_pkg.sv
// Shared types and helpers for the clock-group reset sequencer.
// The optional clock-enable flops are controlled by CLOCK_GROUP_RESET_SEQ_CLKEN_EN.
package clock_group_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } seq_state_t;

    localparam int DEF_N_CH        = 8;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_DELAY_W     = 8;
    localparam int DEF_HOLD_CYCLES = 16;

    // LSB position of channel ch's gap inside the packed release_delay vector.
    function automatic int unsigned delay_lsb(input int unsigned ch, input int unsigned w);
        return ch * w;
    endfunction

endpackage

// File: rtl/clock_group_reset_channel.sv
// One member channel: release/soft-reset flop, soft-reset timer and ack pulse.
// With CLOCK_GROUP_RESET_SEQ_CLKEN_EN defined, out_clock_en is a registered !out_reset.
module clock_group_reset_channel
    import clock_group_pkg::*;
#(
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic release_strobe,
    input  logic run,
    input  logic soft_req,
    output logic soft_ack,
    output logic out_reset,
    output logic out_clock_en
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    logic              req_q;
    logic              armed;
    logic [HOLD_W-1:0] hold_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_reset <= 1'b1;
            soft_ack  <= 1'b0;
            req_q     <= 1'b0;
            armed     <= 1'b1;
            hold_cnt  <= '0;
        end else begin
            req_q    <= soft_req;
            soft_ack <= 1'b0;
            // A held request re-arms only after it has been seen low.
            if (!req_q) armed <= 1'b1;
            if (release_strobe) begin
                out_reset <= 1'b0;
            end else if (run) begin
                if (out_reset) begin
                    if (hold_cnt == HOLD_LAST) begin
                        out_reset <= 1'b0;
                        soft_ack  <= 1'b1;
                        hold_cnt  <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end else if (req_q && armed) begin
                    out_reset <= 1'b1;
                    armed     <= 1'b0;
                    hold_cnt  <= '0;
                end
            end
        end
    end

`ifdef CLOCK_GROUP_RESET_SEQ_CLKEN_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) out_clock_en <= 1'b0;
        else       out_clock_en <= !out_reset;
    end
`else
    assign out_clock_en = 1'b1;
`endif

endmodule

// File: rtl/clock_group_reset_sequencer.sv
// Staged reset release across N_CH member channels, then per-channel soft reset.
// Define CLOCK_GROUP_RESET_SEQ_CLKEN_EN to register the per-channel clock enables.
module clock_group_reset_sequencer
    import clock_group_pkg::*;
#(
    parameter int N_CH        = DEF_N_CH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DELAY_W     = DEF_DELAY_W,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_CH*DELAY_W-1:0] release_delay,
    input  logic [N_CH-1:0]         soft_req,
    output logic [N_CH-1:0]         soft_ack,
    output logic [N_CH-1:0]         out_reset,
    output logic [N_CH-1:0]         out_clock_en,
    output logic                    seq_done
);

    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(N_CH - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    // Reset synchroniser: asserts immediately, deasserts after SYNC_STAGES edges.
    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   rst_s;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) sync_ff <= '1;
        else       sync_ff <= {sync_ff[SYNC_STAGES-2:0], 1'b0};
    end

    assign rst_s = sync_ff[SYNC_STAGES-1];

    seq_state_t        state, state_next;
    logic [HOLD_W-1:0] hold_cnt, hold_next;
    logic [CH_W-1:0]   ch, ch_next, slot_idx;
    logic [DELAY_W-1:0] cnt, cnt_next, cur_delay, delay_next, entry_delay;
    logic              done_next;
    logic [N_CH-1:0]   release_vec;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= HOLD;
            hold_cnt  <= '0;
            ch        <= '0;
            cnt       <= '0;
            cur_delay <= '0;
            seq_done  <= 1'b0;
        end else begin
            state     <= state_next;
            hold_cnt  <= hold_next;
            ch        <= ch_next;
            cnt       <= cnt_next;
            cur_delay <= delay_next;
            seq_done  <= done_next;
        end
    end

    // The gap is latched on slot entry, so later edits to release_delay wait for the next slot.
    always_comb begin
        slot_idx = '0;
        if (state == RELEASE && ch != LAST_CH) slot_idx = ch + 1'b1;
        entry_delay = release_delay[delay_lsb(32'(slot_idx), DELAY_W) +: DELAY_W];
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next  = state;
        hold_next   = hold_cnt;
        ch_next     = ch;
        cnt_next    = cnt;
        delay_next  = cur_delay;
        done_next   = seq_done;
        release_vec = '0;
        case (state)
            HOLD: begin
                if (!rst_s) begin
                    if (hold_cnt == HOLD_LAST) begin
                        state_next = RELEASE;
                        hold_next  = '0;
                        ch_next    = '0;
                        cnt_next   = '0;
                        delay_next = entry_delay;
                    end else begin
                        hold_next = hold_cnt + 1'b1;
                    end
                end
            end
            RELEASE: begin
                if (cnt == cur_delay) begin
                    release_vec[ch] = 1'b1;
                    cnt_next        = '0;
                    if (ch == LAST_CH) begin
                        state_next = RUN;
                        done_next  = 1'b1;
                    end else begin
                        ch_next    = ch + 1'b1;
                        delay_next = entry_delay;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            RUN:     ;
            default: state_next = HOLD;
        endcase
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        clock_group_reset_channel #(
            .HOLD_CYCLES (HOLD_CYCLES)
        ) u_channel (
            .clock          (clock),
            .reset          (reset),
            .release_strobe (release_vec[i]),
            .run            (seq_done),
            .soft_req       (soft_req[i]),
            .soft_ack       (soft_ack[i]),
            .out_reset      (out_reset[i]),
            .out_clock_en   (out_clock_en[i])
        );
    end

endmodule

// File: tb/tb_clock_group_reset_sequencer.sv
// Directed bench: N_CH=4, SYNC_STAGES=2, HOLD_CYCLES=16, delays {0,3,1,2}; outputs traced per edge.
module tb_clock_group_reset_sequencer;

    logic        clock;
    logic        reset;
    logic [31:0] release_delay;
    logic [3:0]  soft_req;
    logic [3:0]  soft_ack;
    logic [3:0]  out_reset;
    logic [3:0]  out_clock_en;
    logic        seq_done;

    int n_pass  = 0;
    int n_total = 0;
    int edge_n  = 0;

    logic [3:0] rst_tr [0:127];
    logic [3:0] ack_tr [0:127];
    logic [3:0] en_tr  [0:127];
    logic       done_tr[0:127];

    clock_group_reset_sequencer #(
        .N_CH        (4),
        .SYNC_STAGES (2),
        .DELAY_W     (8),
        .HOLD_CYCLES (16)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .release_delay (release_delay),
        .soft_req      (soft_req),
        .soft_ack      (soft_ack),
        .out_reset     (out_reset),
        .out_clock_en  (out_clock_en),
        .seq_done      (seq_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_total++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    endtask

    task automatic record();
        rst_tr[edge_n]  = out_reset;
        ack_tr[edge_n]  = soft_ack;
        en_tr[edge_n]   = out_clock_en;
        done_tr[edge_n] = seq_done;
    endtask

    task automatic step();
        @(posedge clock);
        edge_n++;
        #1;
        record();
    endtask

    task automatic run_to(input int n);
        while (edge_n < n) step();
    endtask

    // sig: 0 = out_reset, 1 = out_clock_en, 2 = seq_done. Returns 999 if never seen.
    function automatic int first_at(input int sig, input int b, input logic val, input int lo, input int hi);
        for (int e = lo; e <= hi; e++) begin
            logic v;
            case (sig)
                0:       v = rst_tr[e][b];
                1:       v = en_tr[e][b];
                default: v = done_tr[e];
            endcase
            if (v === val) return e;
        end
        return 999;
    endfunction

    function automatic logic any_rst_high(input int b, input int lo, input int hi);
        logic acc = 1'b0;
        for (int e = lo; e <= hi; e++) acc = acc | rst_tr[e][b];
        return acc;
    endfunction

    task automatic check_power_up(input string pfx);
        check({pfx, "_fall0"}, first_at(0, 0, 1'b0, 1, 40), 19);
        check({pfx, "_fall1"}, first_at(0, 1, 1'b0, 1, 40), 23);
        check({pfx, "_fall2"}, first_at(0, 2, 1'b0, 1, 40), 25);
        check({pfx, "_fall3"}, first_at(0, 3, 1'b0, 1, 40), 28);
        check({pfx, "_done"},  first_at(2, 0, 1'b1, 1, 40), 28);
    endtask

    initial begin
        release_delay = {8'd2, 8'd1, 8'd3, 8'd0};
        soft_req      = 4'b0000;
        reset         = 1'b1;
        #1;
        check("rst_out_reset", 32'(out_reset), 32'hF);
        check("rst_soft_ack",  32'(soft_ack),  32'h0);
        check("rst_seq_done",  32'(seq_done),  32'h0);
`ifdef CLOCK_GROUP_RESET_SEQ_CLKEN_EN
        check("rst_clock_en",  32'(out_clock_en), 32'h0);
`else
        check("rst_clock_en",  32'(out_clock_en), 32'hF);
`endif
        #1;
        reset = 1'b0;
        record();

        // Power-up with an early request on channel 1, then soft resets.
        run_to(4);  soft_req[1] = 1'b1;
        run_to(39); soft_req[2] = 1'b1;
        run_to(46); soft_req[1] = 1'b0;
        run_to(58); soft_req[2] = 1'b0;
        run_to(69); soft_req[0] = 1'b1; soft_req[3] = 1'b1;
        run_to(88); soft_req[3] = 1'b0;
        run_to(95); soft_req[0] = 1'b0;
        run_to(97); soft_req[0] = 1'b1;
        run_to(100);

        check_power_up("pu");
        check("pu_done_before", 32'(done_tr[27]), 32'h0);
`ifdef CLOCK_GROUP_RESET_SEQ_CLKEN_EN
        check("clken0", first_at(1, 0, 1'b1, 0, 40), 20);
        check("clken1", first_at(1, 1, 1'b1, 0, 40), 24);
        check("clken2", first_at(1, 2, 1'b1, 0, 40), 26);
        check("clken3", first_at(1, 3, 1'b1, 0, 40), 29);
`else
        check("clken_e19", 32'(en_tr[19]), 32'hF);
        check("clken_e41", 32'(en_tr[41]), 32'hF);
`endif

        check("early_rise", first_at(0, 1, 1'b1, 24, 60), 29);
        check("early_fall", first_at(0, 1, 1'b0, 29, 60), 45);
        check("early_ack",  32'(ack_tr[45]), 32'h2);

        check("soft2_pre",   32'(rst_tr[40]), 32'h2);
        check("soft2_rise",  first_at(0, 2, 1'b1, 30, 70), 41);
        check("soft2_fall",  first_at(0, 2, 1'b0, 41, 70), 57);
        check("soft2_ack",   32'(ack_tr[57]), 32'h4);
        check("soft2_ack_e56", 32'(ack_tr[56]), 32'h0);
        check("soft2_ack_e58", 32'(ack_tr[58]), 32'h0);
        check("soft2_others", 32'({any_rst_high(3, 41, 57), any_rst_high(0, 41, 57)}), 32'h0);

        check("simul_e70",  32'(rst_tr[70]), 32'h0);
        check("simul_e71",  32'(rst_tr[71]), 32'h9);
        check("simul_e86",  32'(rst_tr[86]), 32'h9);
        check("simul_e87",  32'(rst_tr[87]), 32'h0);
        check("simul_ack",  32'(ack_tr[87]), 32'h9);

        check("rearm_held", 32'(any_rst_high(0, 88, 98)), 32'h0);
        check("rearm_rise", 32'(rst_tr[99][0]), 32'h1);

        // Reset mid-sequence during channel 2's slot, then full restart.
        soft_req = 4'b0000;
        reset    = 1'b1;
        step(); step();
        reset  = 1'b0;
        edge_n = 0;
        run_to(24);
        check("mid_e24", 32'(rst_tr[24]), 32'hC);
        reset = 1'b1;
        #1;
        check("mid_async_rst",  32'(out_reset), 32'hF);
        check("mid_async_done", 32'(seq_done),  32'h0);
        check("mid_async_ack",  32'(soft_ack),  32'h0);
        step(); step();
        reset  = 1'b0;
        edge_n = 0;
        record();
        run_to(32);
        check_power_up("re");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/clock_group_reset_sequencer.md
# clock_group_reset_sequencer

Parametrised successor to the fixed clock-group fan-out. It distributes one clock domain to `N_CH` member domains and adds behaviour the plain fan-out lacks:
- a synchronised, staged reset release, one channel after another with a programmable gap per channel;
- per-channel soft-reset request/acknowledge after bring-up;
- optional per-channel clock enables.

It sits between the top-level clock/reset source and the subsystem buses (sbus, pbus, fbus, mbus, cbus, implicit).

## Interface
- `N_CH`, default 8: number of member channels.
- `SYNC_STAGES`, default 2: reset-deassertion synchroniser depth, ≥2.
- `DELAY_W`, default 8: width of each per-channel release gap.
- `HOLD_CYCLES`, default 16: cycles all resets stay held after sync release; also the soft-reset pulse length; ≥1.
- `clock`  in  1: single clock for the block.
- `reset`  in  1: asynchronous, active-high reset.
- `release_delay`  in  `N_CH*DELAY_W`: gap for channel i in bits `[i*DELAY_W +: DELAY_W]`; sampled at each slot entry.
- `soft_req`  in  `N_CH`: level request; held until the matching ack.
- `soft_ack`  out  `N_CH`: one-cycle pulse when that channel's soft reset completes.
- `out_reset`  out  `N_CH`: active-high reset to member channel i.
- `out_clock_en`  out  `N_CH`: clock enable to member channel i.
- `seq_done`  out  1: high once every channel is released.

## Operation
- **Reset values:** `out_reset` all 1, `out_clock_en` all 0 (macro on), `soft_ack` 0, `seq_done` 0, FSM in `HOLD`, counters 0.
- **Synchroniser:** `reset` asserts the internal `rst_s` immediately (async). Deassertion propagates through `SYNC_STAGES` flops.
- **FSM** (leaves `HOLD` only once `rst_s` is 0):
  - `HOLD`: counts `HOLD_CYCLES`, then goes to `RELEASE` with `ch`=0 and `cnt`=0.
  - `RELEASE`: `cnt` increments each cycle. When `cnt == release_delay[ch]`, `out_reset[ch]` clears at that edge, `cnt` is set to 0 and `ch` increments. After channel `N_CH-1` the FSM goes to `RUN`. Each slot lasts delay+1 cycles, and a delay of 0 is legal.
  - `RUN`: `seq_done`=1; the soft-reset engines are armed.
- **Soft reset** (RUN only, each channel independent): on `soft_req[i]` with the channel idle, `out_reset[i]` rises at the next edge and stays high for `HOLD_CYCLES` cycles. It then falls, and `soft_ack[i]` pulses high at that same edge. A request still high after the ack is treated as a new request only after it has gone low for at least one cycle.
- Requests raised before `RUN` stay pending and are serviced in the first `RUN` cycle.
- Simultaneous requests on several channels run in parallel with identical timing.
- **`reset` asserted at any point:** all state returns to its reset values asynchronously, any in-flight soft reset is aborted without an ack, and the full sequence restarts.
- `release_delay` changes mid-slot take effect only at the next slot entry.

## Timing
- With `reset` deasserted before rising edge 1, `out_reset[0]` falls at edge `SYNC_STAGES + HOLD_CYCLES + d0 + 1`.
- `out_reset[i]` falls `d_i + 1` edges after `out_reset[i-1]` falls.
- `seq_done` rises at the same edge as `out_reset[N_CH-1]` falls.
- Soft reset: request sampled at edge k gives `out_reset[i]` high from edge k+1 to edge k+1+`HOLD_CYCLES`, with `soft_ack` high for the cycle that follows.
- Every output is driven directly by a flop; no combinational path runs from an input to an output.

## Configuration
- `CLOCK_GROUP_RESET_SEQ_CLKEN_EN` defined: `out_clock_en[i]` is a registered copy of `!out_reset[i]`, so it lags one cycle on both edges and resets to 0.
- Macro undefined: `out_clock_en` is tied to all-ones and no flops are generated for it.

## Structure
- Shared package `clock_group_pkg`:
  - FSM state enum: `HOLD`, `RELEASE`, `RUN`.
  - Default parameter constants.
  - Delay-slice helper function.
- Sub-module `clock_group_reset_channel`, one instance per channel:
  - contains the soft-reset counter, the `out_reset` flop, ack generation and the optional clock-enable flop;
  - is driven by a release strobe and a `run` level from the top-level FSM.
- The synchroniser stays inline in the top level.

## Test plan
All scenarios use N_CH=4, SYNC_STAGES=2, HOLD_CYCLES=16 and delays {0,3,1,2}.
- **Power-up:** reset released before edge 1 -> `out_reset` bits fall at edges 19, 23, 25, 28; `seq_done` rises at edge 28.
- **Soft reset:** `soft_req[2]` sampled at edge 40 -> `out_reset[2]` high over edges 41–57, `soft_ack[2]` pulses in the cycle after edge 57, other channels stay 0.
- **Simultaneous requests:** `soft_req[0]` and `soft_req[3]` sampled at the same edge -> identical 16-cycle pulses and simultaneous acks.
- **Reset mid-sequence:** `reset` asserted at edge 24, during channel 2's slot -> all `out_reset`=1 and `seq_done`=0 immediately; after release the sequence repeats with the same edge offsets.
- **Early request:** `soft_req[1]` high from edge 5 -> no action until `RUN`, then a pulse starting at edge 29.
- **Macro on:** each `out_clock_en[i]` rises one edge after `out_reset[i]` falls (20, 24, 26, 29). Macro off: constant 4'b1111.
